keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Input-side counterpart of the 8-digit LED scanner: scans a 4x4 matrix keypad at 1 kHz.
//  Drives rows active-low, samples pulled-up active-low columns, debounces press/release.
//  Emits one key_valid pulse with a 4-bit key code per debounced press.
//  Sits beside the LED scanner on the experiment board, clocked by the same clk_1kHz divider output.
// PARAMETERS
//  DEBOUNCE_MS  20  consecutive stable cycles (1 ms each) required to accept a press or a release
//  SETTLE_CYC   3   cycles each row is driven during SCAN; col sampled on last cycle (>=3, covers 2-flop sync)
// PORTS
//  clk_1kHz   in   1  scan clock, 1 kHz
//  rst_n      in   1  reset, asynchronous, active-low
//  col_n      in   4  keypad columns, active-low, asynchronous to clk_1kHz
//  row_n      out  4  keypad row drive, active-low
//  key_code   out  4  {row_idx[1:0], col_idx[1:0]} of last accepted key; holds until next accept
//  key_valid  out  1  one-cycle pulse on acceptance of a press
//  key_down   out  1  high from acceptance until debounced release
//  key_err    out  1  one-cycle pulse when >1 column low in one scanned row (multi-key)
// BEHAVIOUR
//  Reset: row_n=4'b0000, key_code=0, key_valid=0, key_down=0, key_err=0, state IDLE, counters 0.
//  col_n passes through 2-flop sync (reset value 4'b1111); all decisions use col_s (synchronised).
//  All outputs registered.
//  IDLE: row_n=0000. col_s!=1111 -> DEB_PRESS, cnt=0.
//  DEB_PRESS: row_n=0000. col_s==1111 -> IDLE (glitch rejected).
//    Else cnt++; at cnt==DEBOUNCE_MS-1 -> SCAN, row_idx=0, settle=0.
//  SCAN: row_n=~(4'b0001<<row_idx); settle++ each cycle; on settle==SETTLE_CYC-1 sample col_s:
//    exactly one col low -> latch key_code, assert key_valid next cycle, key_down=1 -> PRESSED.
//    >1 col low -> key_err pulse -> WAIT_REL.
//    none low, row_idx<3 -> row_idx++, settle=0.
//    none low, row_idx==3 -> IDLE (key lost during scan, no pulse).
//  PRESSED: hold row_n on the found row; col_s[col_idx]==1 -> DEB_REL, cnt=0.
//  DEB_REL: row_n held; col_s[col_idx]==0 -> PRESSED (bounce; no new key_valid).
//    Else cnt++; at cnt==DEBOUNCE_MS-1 -> key_down=0 -> IDLE.
//  WAIT_REL: row_n=0000; needs col_s==1111 for DEBOUNCE_MS consecutive cycles -> IDLE; any low restarts cnt.
//  A second key pressed while PRESSED is ignored (only col_idx watched); no rollover.
//  key_valid and key_err never both high; each exactly 1 cycle.
//  cnt width $clog2(DEBOUNCE_MS+1); settle width $clog2(SETTLE_CYC+1); no wrap reachable.
//  Reset mid-operation: all state/outputs return to reset values asynchronously; no pulse on exit.
//  Worst-case press latency from col_n edge to key_valid: 2 + DEBOUNCE_MS + 4*SETTLE_CYC + 1 cycles.
// STRUCTURE
//  kbd_pkg: typedef enum logic [2:0] {IDLE,DEB_PRESS,SCAN,PRESSED,DEB_REL,WAIT_REL} kbd_state_t;
//    localparams KBD_ROWS=4, KBD_COLS=4.
//  Sub-module sync2 #(.W(4), .RST_VAL(4'hF)): 2-flop synchroniser for col_n; FSM and counters inline.
//  Column index via priority encoder + popcount==1 check, both combinational on col_s.
// TESTING (DEBOUNCE_MS=20, SETTLE_CYC=3; keypad model shorts row r to col c when key pressed)
//  1 Reset: hold rst_n=0 5 cycles -> row_n=0000, key_code=0, key_valid/key_down/key_err=0.
//  2 Press row2/col1, hold 100 ms -> one key_valid, key_code=4'h9, key_down=1, latency <=35 cycles;
//    release 40 ms -> key_down=0 after 22 cycles, state IDLE.
//  3 Glitch: col_n[0] low 5 cycles then high -> no key_valid, no key_err, back to IDLE, row_n=0000.
//  4 Release bounce: in PRESSED (key 4'h5) col high 3 cycles, low 10, then high 30 -> single key_valid total,
//    key_down stays 1 through bounce, falls 22 cycles after final release.
//  5 Multi-key: row1 col0 + row1 col3 pressed together -> key_err pulse, no key_valid;
//    key_code unchanged; IDLE only 20 cycles after both released.
//  6 Reset mid-PRESSED (key 4'hF held): rst_n low 1 cycle -> key_down=0, key_code=0, row_n=0000 immediately;
//    after release, key still held -> fresh key_valid with code 4'hF.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package kbd_pkg;

  localparam int unsigned KBD_ROWS = 4;
  localparam int unsigned KBD_COLS = 4;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned CODE_W   = ROW_W + COL_W;
  localparam int unsigned LOWS_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    SCAN,
    PRESSED,
    DEB_REL,
    WAIT_REL
  } kbd_state_t;

  // Index of the lowest-numbered active column (columns given active-high).
  function automatic logic [COL_W-1:0] first_col(input logic [KBD_COLS-1:0] lows);
    logic [COL_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(KBD_COLS); i++) begin
      if (lows[i] && !found) begin
        idx   = COL_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [LOWS_W-1:0] count_cols(input logic [KBD_COLS-1:0] lows);
    logic [LOWS_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(KBD_COLS); i++) begin
      n = n + LOWS_W'(lows[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchroniser with a configurable reset value.
module sync2 #(
  parameter int unsigned W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: debounced press detection, row scan, key code and multi-key report.
module keypad_scan
  import kbd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SETTLE_CYC  = 3
) (
  input  logic                clk_1kHz,
  input  logic                rst_n,
  input  logic [KBD_COLS-1:0] col_n,
  output logic [KBD_ROWS-1:0] row_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_down,
  output logic                key_err
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KBD_ROWS - 1);

  logic [KBD_COLS-1:0] col_s;
  logic [KBD_COLS-1:0] lows;
  logic [COL_W-1:0]    enc;
  logic [LOWS_W-1:0]   n_low;

  kbd_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic [COL_W-1:0]    col_idx_q, col_idx_d;
  logic [KBD_ROWS-1:0] row_n_d;
  logic [CODE_W-1:0]   key_code_d;
  logic                key_valid_d, key_down_d, key_err_d;

  sync2 #(.W(KBD_COLS), .RST_VAL(4'hF)) u_col_sync (
    .clk   (clk_1kHz),
    .rst_n (rst_n),
    .d     (col_n),
    .q     (col_s)
  );

  assign lows  = ~col_s;
  assign enc   = first_col(lows);
  assign n_low = count_cols(lows);

  // State, counters and registered outputs.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      settle_q  <= '0;
      row_idx_q <= '0;
      col_idx_q <= '0;
      row_n     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      row_n     <= row_n_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_down  <= key_down_d;
      key_err   <= key_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    key_code_d  = key_code;
    key_valid_d = 1'b0;
    key_err_d   = 1'b0;
    key_down_d  = key_down;

    case (state_q)
      IDLE: begin
        if (col_s != '1) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (col_s == '1) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = SCAN;
          row_idx_d = '0;
          settle_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCAN: begin
        if (settle_q == SET_LAST) begin
          if (n_low == LOWS_W'(1)) begin
            col_idx_d   = enc;
            key_code_d  = {row_idx_q, enc};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = PRESSED;
          end else if (n_low > LOWS_W'(1)) begin
            key_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT_REL;
          end else if (row_idx_q != ROW_LAST) begin
            row_idx_d = row_idx_q + ROW_W'(1);
            settle_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      PRESSED: begin
        if (col_s[col_idx_q]) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end
      end
      DEB_REL: begin
        if (!col_s[col_idx_q]) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          key_down_d = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (col_s != '1) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Only the scan and held-key states drive a single row; elsewhere all rows are driven.
    if (state_d == SCAN || state_d == PRESSED || state_d == DEB_REL) begin
      row_n_d = ~(KBD_ROWS'(1) << row_idx_d);
    end else begin
      row_n_d = '0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with a resistive-short keypad model.
`timescale 1us/1ns
module tb_keypad_scan;

  logic       clk_1kHz;
  logic       rst_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       key_err;

  logic [15:0] keys;
  logic [3:0]  force_low;
  logic [3:0]  col_model;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  keypad_scan #(.DEBOUNCE_MS(20), .SETTLE_CYC(3)) dut (
    .clk_1kHz  (clk_1kHz),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .key_err   (key_err)
  );

  initial begin
    clk_1kHz = 1'b0;
    forever #500 clk_1kHz = ~clk_1kHz;
  end

  // Pressed key at (r,c) pulls column c low whenever row r is driven low.
  always_comb begin
    col_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_model[c] = 1'b0;
  end
  assign col_n = col_model & ~force_low;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // Monitor: every key_valid / key_err pulse must match the next queued event {err, code}.
  always @(negedge clk_1kHz) begin
    if (rst_n && (key_valid || key_err)) begin
      check("valid_err_exclusive", 32'(key_valid & key_err), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event got err=%0b code=%0h want none", key_err, key_code);
      end else begin
        check("event", 32'({key_err, key_code}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_1kHz);
  endtask

  // Cycles from now until the selected pulse appears (999 on timeout).
  task automatic wait_pulse(input string name, input bit err_sel, input int exp_lat);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < 60) begin
      @(negedge clk_1kHz);
      n++;
      if (err_sel ? key_err : key_valid) found = 1'b1;
    end
    check(name, found ? 32'(n) : 32'd999, 32'(exp_lat));
  endtask

  task automatic wait_down_fall(input string name);
    int n;
    n = 0;
    while (key_down && n < 60) begin
      @(negedge clk_1kHz);
      n++;
    end
    if (n < 22 || n > 23) begin
      checks++;
      errors++;
      $display("FAIL %s got %0d cycles want 22..23", name, n);
    end else begin
      check(name, 32'(key_down), 32'h0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    keys      = '0;
    force_low = '0;

    // Reset state
    cyc(5);
    check("rst_row_n", 32'(row_n), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_flags", 32'({key_valid, key_down, key_err}), 32'h0);
    rst_n = 1'b1;
    cyc(3);

    // Single press row2/col1
    exp_q.push_back({1'b0, 4'h9});
    keys[9] = 1'b1;
    wait_pulse("lat_key9", 1'b0, 32);
    check("code_key9", 32'(key_code), 32'h9);
    check("down_key9", 32'(key_down), 32'h1);
    cyc(60);
    check("hold_down_key9", 32'(key_down), 32'h1);
    check("hold_row_key9", 32'(row_n), 32'hB);
    keys = '0;
    wait_down_fall("rel_key9");
    check("idle_row_key9", 32'(row_n), 32'h0);
    cyc(20);

    // Short glitch on column 0
    force_low = 4'b0001;
    cyc(5);
    force_low = '0;
    cyc(30);
    check("glitch_row", 32'(row_n), 32'h0);
    check("glitch_down", 32'(key_down), 32'h0);
    check("glitch_code", 32'(key_code), 32'h9);

    // Release bounce on key 5
    exp_q.push_back({1'b0, 4'h5});
    keys[5] = 1'b1;
    wait_pulse("lat_key5", 1'b0, 29);
    keys = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("bounce_up_down", 32'(key_down), 32'h1);
    end
    keys[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("bounce_dn_down", 32'(key_down), 32'h1);
    end
    keys = '0;
    wait_down_fall("rel_key5");
    cyc(10);

    // Two keys in row 1
    exp_q.push_back({1'b1, 4'h5});
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    wait_pulse("lat_multi", 1'b1, 29);
    check("multi_code", 32'(key_code), 32'h5);
    check("multi_down", 32'(key_down), 32'h0);
    cyc(10);
    keys = '0;
    cyc(10);
    // Still releasing: a new press must restart the release wait and not be accepted.
    keys[0] = 1'b1;
    cyc(40);
    check("multi_wait_row", 32'(row_n), 32'h0);
    keys = '0;
    cyc(30);
    exp_q.push_back({1'b0, 4'h0});
    keys[0] = 1'b1;
    wait_pulse("lat_key0", 1'b0, 26);
    keys = '0;
    wait_down_fall("rel_key0");
    cyc(10);

    // Reset while key F held
    exp_q.push_back({1'b0, 4'hF});
    keys[15] = 1'b1;
    wait_pulse("lat_keyF", 1'b0, 35);
    cyc(5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_down", 32'(key_down), 32'h0);
    check("rst_mid_code", 32'(key_code), 32'h0);
    check("rst_mid_row", 32'(row_n), 32'h0);
    @(negedge clk_1kHz);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 4'hF});
    wait_pulse("lat_keyF_again", 1'b0, 35);
    check("code_keyF_again", 32'(key_code), 32'hF);
    keys = '0;
    wait_down_fall("rel_keyF");
    cyc(5);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
